decode_scoreboard: RTL and testbench
====================================

Name: decode_scoreboard

Overview:
- Register-hazard scoreboard and issue controller for the decode stage.
- Tracks outstanding writes to each architectural register, and gates decode issue (`dec_ready`) on RAW and WAW-saturation hazards, external stall, and drain requests.
- Retires pending writes at writeback and cancels writes of squashed instructions on branch flush.
- Sits beside decode; its outputs feed the pipeline stall/enable logic and the register file write path.

Parameters:
- CNT_W, 2, width of per-register pending-write counter; max outstanding writes per register = 2^CNT_W-1
- NUM_CANCEL, 2, number of cancel ports (squashed in-flight writers per cycle)
- WB_BYPASS, 1, 1 = writeback retiring a register in the same cycle clears its RAW hazard for that cycle's issue

Ports:
- clk  in  1  clock
- rst  in  1  reset; asynchronous, active-high
- mstall_n  in  1  active-low external stall; 0 forces dec_ready=0
- dec_valid  in  1  decode holds a valid instruction
- dec_rs1  in  5  source register 1
- dec_rs2  in  5  source register 2
- dec_use_rs1  in  1  instruction reads rs1
- dec_use_rs2  in  1  instruction reads rs2
- dec_rd  in  5  destination register
- dec_we  in  1  instruction writes rd
- dec_ready  out  1  instruction may issue this cycle; issue = dec_valid & dec_ready
- wb_valid  in  1  writeback retiring a write
- wb_rd  in  5  register retired
- cancel_valid  in  NUM_CANCEL  per-port squash of an in-flight writer
- cancel_rd  in  5*NUM_CANCEL  rd of each squashed writer, port i at [5i+4:5i]
- drain_req  in  1  level; request that all outstanding writes complete (fence, CSR, trap entry)
- drain_done  out  1  drain complete
- busy_vec  out  32  bit r = counter[r] != 0; bit 0 always 0
- sb_err  out  1  sticky: retire/cancel hit a zero counter

Behaviour:
- Reset (async, rst=1): all counters = 0, FSM = RUN, sb_err = 0. Outputs then: busy_vec = 0, drain_done = 0, dec_ready = mstall_n & !drain_req.
- Register x0:
  - Never tracked; issue, retire and cancel targeting rd=0 are ignored.
  - rs=0 never hazards.
- RAW hazard on source s: use_s & rs_s != 0 & counter[rs_s] != 0.
  - With WB_BYPASS=1 and wb_valid & wb_rd==rs_s & counter[rs_s]==1, the hazard is cleared for that cycle.
- WAW saturation: dec_we & dec_rd != 0 & counter[dec_rd] == max, with no same-cycle retire or cancel of dec_rd.
- dec_ready = mstall_n & FSM==RUN & !drain_req & !RAW1 & !RAW2 & !WAWsat.
  - Combinational from current state plus same-cycle wb/cancel.
  - Independent of dec_valid.
- Counter update (registered, visible next cycle): counter[r] += inc - dec.
  - inc = issue & dec_we & dec_rd==r.
  - dec = (wb_valid & wb_rd==r) + count of cancel ports hitting r.
  - All simultaneous events on the same r are summed.
- Underflow: if dec exceeds counter+inc, counter saturates at 0 and sb_err is set (cleared only by rst).
- Overflow: cannot occur, because WAWsat blocks the issue.
- FSM:
  - RUN: drain_req=1 → DRAIN (no issue in that cycle).
  - DRAIN: dec_ready=0; when all counters == 0 and no same-cycle inc → DONE.
  - DONE: drain_done=1, dec_ready=0; drain_req=0 → RUN.
  - drain_req dropping while in DRAIN → RUN directly; drain_done is not pulsed.
  - Entering DRAIN with all counters already 0 reaches DONE on the next cycle (minimum 2-cycle latency req→done).
- Cancels and retires are accepted in every FSM state and during mstall_n=0.
- rst asserted mid-drain or with writes in flight drops all tracking immediately. The pipeline is reset concurrently, so no stale retires are expected.

Decomposition:
- Shared package rv_core_pkg:
  - REG_IDX_W=5, NUM_REGS=32.
  - sb_state_t enum {SB_RUN, SB_DRAIN, SB_DONE}.
  - Register-index typedef reg_idx_t.
- Sub-module sb_counter_bank: the 31 saturating up/down counters with summed decrement and underflow flag.
  - Outputs counter array plus a zero-vector.
- Top level holds the hazard compare, ready logic and FSM.

Test Plan:
- Reset, then issue rd=5; next cycle dec_rs1=5, use_rs1=1 → dec_ready=0 and busy_vec[5]=1.
- WB_BYPASS: wb_valid, wb_rd=5 in the same cycle → dec_ready=1; the following cycle busy_vec[5]=0.
- WAW saturation:
  - Issue rd=7 three times with no retire → counter=3 (max for CNT_W=2).
  - A 4th issue with rd=7 → dec_ready=0.
  - The same 4th issue together with wb_rd=7 → dec_ready=1 and the counter stays 3.
- Simultaneous events: issue rd=9 while counter[9]=2, with wb_rd=9 and cancel port 0 rd=9 → counter[9]=1 next cycle and sb_err=0.
- Underflow: cancel rd=12 with counter 0 → counter stays 0 and sb_err=1 until rst.
- x0 handling: issue rd=0 and read rs1=0 → busy_vec=0 and dec_ready=1.
- Drain, normal path:
  - Set counters[3]=1, [4]=2 and assert drain_req → dec_ready=0 and FSM=DRAIN.
  - Retire 3, 4, 4 over 3 cycles → drain_done=1 the cycle after the last retire.
  - Drop drain_req → dec_ready=1 next cycle.
- Drain, edge cases:
  - mstall_n=0 → dec_ready=0 while wb retires still decrement.
  - drain_req dropped in DRAIN → RUN without a drain_done pulse.

Source files
------------

// File: rtl/decode_scoreboard_pkg.sv
// Shared core definitions for the decode-stage register scoreboard:
// register index types, scoreboard FSM states and a one-hot decode helper.
package rv_core_pkg;

   localparam int REG_IDX_W = 5;
   localparam int NUM_REGS  = 32;

   typedef logic [REG_IDX_W-1:0] reg_idx_t;

   typedef enum logic [1:0] {
      SB_RUN   = 2'd0,
      SB_DRAIN = 2'd1,
      SB_DONE  = 2'd2
   } sb_state_t;

   // x0 is never tracked, so its bit is always masked off
   function automatic logic [NUM_REGS-1:0] reg_onehot(input reg_idx_t idx, input logic en);
      logic [NUM_REGS-1:0] vec;
      vec = '0;
      if (en && (idx != '0)) begin
         vec[idx] = 1'b1;
      end else begin
         vec = '0;
      end
      return vec;
   endfunction

endpackage

// File: rtl/decode_scoreboard_counter_bank.sv
// Per-register pending-write counters: one increment source, summed retire/cancel
// decrements, saturation at zero on underflow with a sticky error flag.
module sb_counter_bank
   import rv_core_pkg::*;
#(
   parameter int CNT_W      = 2,
   parameter int NUM_CANCEL = 2
) (
   input  logic                            clk,
   input  logic                            rst,
   input  logic                            inc_en_i,
   input  logic [REG_IDX_W-1:0]            inc_rd_i,
   input  logic                            wb_valid_i,
   input  logic [REG_IDX_W-1:0]            wb_rd_i,
   input  logic [NUM_CANCEL-1:0]           cancel_valid_i,
   input  logic [REG_IDX_W*NUM_CANCEL-1:0] cancel_rd_i,
   output logic [NUM_REGS*CNT_W-1:0]       cnt_flat_o,
   output logic [NUM_REGS-1:0]             zero_vec_o,
   output logic                            all_zero_nxt_o,
   output logic                            uflow_err_o
);

   localparam int DEC_W = $clog2(NUM_CANCEL + 2);
   localparam int SUM_W = ((CNT_W > DEC_W) ? CNT_W : DEC_W) + 1;

   logic [CNT_W-1:0]    cnt_q   [NUM_REGS];
   logic [CNT_W-1:0]    cnt_d   [NUM_REGS];
   logic [SUM_W-1:0]    dec_sum [NUM_REGS];
   logic [SUM_W-1:0]    tot_sum [NUM_REGS];
   logic [NUM_REGS-1:0] inc_vec;
   logic [NUM_REGS-1:0] wb_vec;
   logic [NUM_REGS-1:0] uflow_vec;
   logic                err_q;
   logic                err_d;
   logic                all_zero_d;

   // Sum every same-cycle event per register and saturate the result at zero
   always_comb begin
      inc_vec    = reg_onehot(inc_rd_i, inc_en_i);
      wb_vec     = reg_onehot(wb_rd_i, wb_valid_i);
      uflow_vec  = '0;
      all_zero_d = 1'b1;
      for (int r = 0; r < NUM_REGS; r++) begin
         dec_sum[r] = SUM_W'(wb_vec[r]);
         tot_sum[r] = SUM_W'(cnt_q[r]) + SUM_W'(inc_vec[r]);
         for (int c = 0; c < NUM_CANCEL; c++) begin
            dec_sum[r] = dec_sum[r] +
                         SUM_W'(cancel_valid_i[c] &&
                                (cancel_rd_i[REG_IDX_W*c +: REG_IDX_W] == REG_IDX_W'(r)));
         end
         if (r == 0) begin
            cnt_d[r] = '0;
         end else if (dec_sum[r] > tot_sum[r]) begin
            cnt_d[r]     = '0;
            uflow_vec[r] = 1'b1;
         end else begin
            cnt_d[r] = CNT_W'(tot_sum[r] - dec_sum[r]);
         end
         all_zero_d = all_zero_d & (cnt_d[r] == '0);
      end
      err_d = err_q | (|uflow_vec);
   end

   // Counter and sticky error state
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_q <= '{default: '0};
         err_q <= 1'b0;
      end else begin
         cnt_q <= cnt_d;
         err_q <= err_d;
      end
   end

   // Flatten the counter array and derive the per-register zero flags
   always_comb begin
      cnt_flat_o = '0;
      zero_vec_o = '0;
      for (int r = 0; r < NUM_REGS; r++) begin
         cnt_flat_o[r*CNT_W +: CNT_W] = cnt_q[r];
         zero_vec_o[r]                = (cnt_q[r] == '0);
      end
   end

   assign all_zero_nxt_o = all_zero_d;
   assign uflow_err_o    = err_q;

endmodule

// File: rtl/decode_scoreboard.sv
// Decode-stage register scoreboard: RAW / WAW-saturation hazard detection,
// issue gating and the drain handshake used by fences, CSR ops and traps.
module decode_scoreboard
   import rv_core_pkg::*;
#(
   parameter int CNT_W      = 2,
   parameter int NUM_CANCEL = 2,
   parameter int WB_BYPASS  = 1
) (
   input  logic                            clk,
   input  logic                            rst,
   input  logic                            mstall_n,
   input  logic                            dec_valid,
   input  logic [REG_IDX_W-1:0]            dec_rs1,
   input  logic [REG_IDX_W-1:0]            dec_rs2,
   input  logic                            dec_use_rs1,
   input  logic                            dec_use_rs2,
   input  logic [REG_IDX_W-1:0]            dec_rd,
   input  logic                            dec_we,
   output logic                            dec_ready,
   input  logic                            wb_valid,
   input  logic [REG_IDX_W-1:0]            wb_rd,
   input  logic [NUM_CANCEL-1:0]           cancel_valid,
   input  logic [REG_IDX_W*NUM_CANCEL-1:0] cancel_rd,
   input  logic                            drain_req,
   output logic                            drain_done,
   output logic [NUM_REGS-1:0]             busy_vec,
   output logic                            sb_err
);

   localparam logic [CNT_W-1:0] CNT_MAX = '1;
   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

   sb_state_t            state_q;
   sb_state_t            state_d;
   logic [NUM_REGS*CNT_W-1:0] cnt_flat_s;
   logic [CNT_W-1:0]     cnt_s [NUM_REGS];
   logic [NUM_REGS-1:0]  zero_vec_s;
   logic                 all_zero_nxt_s;
   logic                 uflow_err_s;
   logic                 wb_clr1_s;
   logic                 wb_clr2_s;
   logic                 raw1_s;
   logic                 raw2_s;
   logic                 rd_kill_s;
   logic                 waw_sat_s;
   logic                 ready_s;
   logic                 issue_s;

   sb_counter_bank #(
      .CNT_W      (CNT_W),
      .NUM_CANCEL (NUM_CANCEL)
   ) u_bank (
      .clk            (clk),
      .rst            (rst),
      .inc_en_i       (issue_s),
      .inc_rd_i       (dec_rd),
      .wb_valid_i     (wb_valid),
      .wb_rd_i        (wb_rd),
      .cancel_valid_i (cancel_valid),
      .cancel_rd_i    (cancel_rd),
      .cnt_flat_o     (cnt_flat_s),
      .zero_vec_o     (zero_vec_s),
      .all_zero_nxt_o (all_zero_nxt_s),
      .uflow_err_o    (uflow_err_s)
   );

   // Unpack counters for indexed lookup by source/destination register
   always_comb begin
      for (int r = 0; r < NUM_REGS; r++) begin
         cnt_s[r] = cnt_flat_s[r*CNT_W +: CNT_W];
      end
   end

   // Hazard detection; a writeback retiring the last pending write clears RAW early
   always_comb begin
      wb_clr1_s = (WB_BYPASS != 0) && wb_valid && (wb_rd == dec_rs1) && (cnt_s[dec_rs1] == CNT_ONE);
      wb_clr2_s = (WB_BYPASS != 0) && wb_valid && (wb_rd == dec_rs2) && (cnt_s[dec_rs2] == CNT_ONE);
      raw1_s    = dec_use_rs1 && (dec_rs1 != 5'd0) && !zero_vec_s[dec_rs1] && !wb_clr1_s;
      raw2_s    = dec_use_rs2 && (dec_rs2 != 5'd0) && !zero_vec_s[dec_rs2] && !wb_clr2_s;
      rd_kill_s = wb_valid && (wb_rd == dec_rd);
      for (int c = 0; c < NUM_CANCEL; c++) begin
         rd_kill_s = rd_kill_s |
                     (cancel_valid[c] && (cancel_rd[REG_IDX_W*c +: REG_IDX_W] == dec_rd));
      end
      waw_sat_s = dec_we && (dec_rd != 5'd0) && (cnt_s[dec_rd] == CNT_MAX) && !rd_kill_s;
      ready_s   = mstall_n && (state_q == SB_RUN) && !drain_req && !raw1_s && !raw2_s && !waw_sat_s;
      issue_s   = dec_valid && ready_s && dec_we;
   end

   // FSM state register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= SB_RUN;
      end else begin
         state_q <= state_d;
      end
   end

   // Drain sequencing: DONE only once the post-update counters are all zero
   always_comb begin
      state_d = state_q;
      case (state_q)
         SB_RUN: begin
            if (drain_req) begin
               state_d = SB_DRAIN;
            end else begin
               state_d = SB_RUN;
            end
         end
         SB_DRAIN: begin
            if (!drain_req) begin
               state_d = SB_RUN;
            end else if (all_zero_nxt_s) begin
               state_d = SB_DONE;
            end else begin
               state_d = SB_DRAIN;
            end
         end
         SB_DONE: begin
            if (!drain_req) begin
               state_d = SB_RUN;
            end else begin
               state_d = SB_DONE;
            end
         end
         default: begin
            state_d = SB_RUN;
         end
      endcase
   end

   assign dec_ready  = ready_s;
   assign drain_done = (state_q == SB_DONE);
   assign busy_vec   = ~zero_vec_s & {{(NUM_REGS-1){1'b1}}, 1'b0};
   assign sb_err     = uflow_err_s;

endmodule

// File: tb/tb_decode_scoreboard.sv
// Scoreboard bench: stimulus pushes predicted outputs from a counting model,
// a negedge monitor pops and compares them against the DUT.
module tb_decode_scoreboard;

   localparam int NUM_CANCEL = 2;
   localparam int MAX_CNT    = 3;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        mstall_n = 1'b1;
   logic        dec_valid = 1'b0;
   logic [4:0]  dec_rs1 = 5'd0;
   logic [4:0]  dec_rs2 = 5'd0;
   logic        dec_use_rs1 = 1'b0;
   logic        dec_use_rs2 = 1'b0;
   logic [4:0]  dec_rd = 5'd0;
   logic        dec_we = 1'b0;
   logic        dec_ready;
   logic        wb_valid = 1'b0;
   logic [4:0]  wb_rd = 5'd0;
   logic [1:0]  cancel_valid = 2'b00;
   logic [9:0]  cancel_rd = 10'd0;
   logic        drain_req = 1'b0;
   logic        drain_done;
   logic [31:0] busy_vec;
   logic        sb_err;

   always #5 clk = ~clk;

   decode_scoreboard #(.CNT_W(2), .NUM_CANCEL(NUM_CANCEL), .WB_BYPASS(1)) dut (
      .clk(clk), .rst(rst), .mstall_n(mstall_n), .dec_valid(dec_valid),
      .dec_rs1(dec_rs1), .dec_rs2(dec_rs2), .dec_use_rs1(dec_use_rs1),
      .dec_use_rs2(dec_use_rs2), .dec_rd(dec_rd), .dec_we(dec_we),
      .dec_ready(dec_ready), .wb_valid(wb_valid), .wb_rd(wb_rd),
      .cancel_valid(cancel_valid), .cancel_rd(cancel_rd), .drain_req(drain_req),
      .drain_done(drain_done), .busy_vec(busy_vec), .sb_err(sb_err)
   );

   typedef struct {
      logic        rdy;
      logic [31:0] busy;
      logic        done;
      logic        err;
      int          cyc;
   } exp_t;

   exp_t exp_q[$];
   int   errors = 0;
   int   checks = 0;
   int   cyc = 0;

   // reference model: pending-write counts per register, drain mode, sticky error
   int   m_cnt[32];
   int   m_mode;   // 0 running, 1 draining, 2 drain complete
   bit   m_err;

   function automatic int decs(input int r);
      int d = 0;
      if (r == 0) return 0;
      if (wb_valid && int'(wb_rd) == r) d++;
      for (int c = 0; c < NUM_CANCEL; c++)
         if (cancel_valid[c] && int'(cancel_rd[5*c +: 5]) == r) d++;
      return d;
   endfunction

   function automatic bit raw(input bit use_s, input logic [4:0] rs);
      if (!use_s || rs == 5'd0 || m_cnt[rs] == 0) return 1'b0;
      if (wb_valid && wb_rd == rs && m_cnt[rs] == 1) return 1'b0;
      return 1'b1;
   endfunction

   task automatic model_reset();
      for (int r = 0; r < 32; r++) m_cnt[r] = 0;
      m_mode = 0;
      m_err  = 1'b0;
   endtask

   // predict this cycle's outputs, queue them, advance the model, advance time
   task automatic tick();
      exp_t e;
      bit   waw, all_zero;
      int   v;
      waw = dec_we && dec_rd != 5'd0 && m_cnt[dec_rd] == MAX_CNT && decs(int'(dec_rd)) == 0;
      e.rdy  = mstall_n && m_mode == 0 && !drain_req &&
               !raw(dec_use_rs1, dec_rs1) && !raw(dec_use_rs2, dec_rs2) && !waw;
      e.busy = '0;
      for (int r = 1; r < 32; r++) e.busy[r] = (m_cnt[r] != 0);
      e.done = (m_mode == 2);
      e.err  = m_err;
      e.cyc  = cyc;
      exp_q.push_back(e);
      if (!rst) begin
         all_zero = 1'b1;
         for (int r = 1; r < 32; r++) begin
            v = m_cnt[r] + ((dec_valid && e.rdy && dec_we && int'(dec_rd) == r) ? 1 : 0) - decs(r);
            if (v < 0) begin
               v = 0;
               m_err = 1'b1;
            end
            m_cnt[r] = v;
            if (v != 0) all_zero = 1'b0;
         end
         if (m_mode == 0) m_mode = drain_req ? 1 : 0;
         else if (!drain_req) m_mode = 0;
         else if (m_mode == 1 && all_zero) m_mode = 2;
      end
      @(posedge clk);
      #1;
      cyc++;
   endtask

   task automatic clr();
      mstall_n = 1'b1; dec_valid = 1'b0; dec_we = 1'b0; dec_rd = 5'd0;
      dec_rs1 = 5'd0; dec_rs2 = 5'd0; dec_use_rs1 = 1'b0; dec_use_rs2 = 1'b0;
      wb_valid = 1'b0; wb_rd = 5'd0; cancel_valid = 2'b00; cancel_rd = 10'd0;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      model_reset();
      tick();
      rst = 1'b0;
   endtask

   task automatic issue_wr(input logic [4:0] rd);
      clr(); dec_valid = 1'b1; dec_we = 1'b1; dec_rd = rd; tick();
   endtask

   task automatic retire(input logic [4:0] rd);
      clr(); wb_valid = 1'b1; wb_rd = rd; tick();
   endtask

   function automatic logic [4:0] pick_pending();
      int r;
      for (int t = 0; t < 8; t++) begin
         r = $urandom_range(1, 7);
         if (m_cnt[r] > 0) return 5'(r);
      end
      return 5'd0;
   endfunction

   // monitor: compare the DUT against the oldest prediction, mid-cycle
   always @(negedge clk) begin
      exp_t e;
      if (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         checks += 4;
         if (dec_ready !== e.rdy) begin
            errors++;
            $display("FAIL dec_ready cyc=%0d got=%b exp=%b", e.cyc, dec_ready, e.rdy);
         end
         if (busy_vec !== e.busy) begin
            errors++;
            $display("FAIL busy_vec cyc=%0d got=%h exp=%h", e.cyc, busy_vec, e.busy);
         end
         if (drain_done !== e.done) begin
            errors++;
            $display("FAIL drain_done cyc=%0d got=%b exp=%b", e.cyc, drain_done, e.done);
         end
         if (sb_err !== e.err) begin
            errors++;
            $display("FAIL sb_err cyc=%0d got=%b exp=%b", e.cyc, sb_err, e.err);
         end
      end
   end

   initial begin
      model_reset();
      @(posedge clk);
      #1;
      do_reset();
      tick();

      // RAW on rd=5, then cleared by same-cycle writeback
      issue_wr(5'd5);
      clr(); dec_valid = 1'b1; dec_use_rs1 = 1'b1; dec_rs1 = 5'd5; tick();
      wb_valid = 1'b1; wb_rd = 5'd5; tick();
      clr(); tick();

      // WAW saturation on rd=7
      repeat (3) issue_wr(5'd7);
      issue_wr(5'd7);
      wb_valid = 1'b1; wb_rd = 5'd7; tick();
      repeat (3) retire(5'd7);

      // issue + writeback + cancel on rd=9 together
      issue_wr(5'd9); issue_wr(5'd9);
      clr(); dec_valid = 1'b1; dec_we = 1'b1; dec_rd = 5'd9;
      wb_valid = 1'b1; wb_rd = 5'd9; cancel_valid = 2'b01; cancel_rd = {5'd0, 5'd9}; tick();
      retire(5'd9);

      // underflow on cancel to an idle register
      clr(); cancel_valid = 2'b10; cancel_rd = {5'd12, 5'd0}; tick();
      clr(); tick(); tick();
      do_reset();

      // x0 never tracked
      clr(); dec_valid = 1'b1; dec_we = 1'b1; dec_rd = 5'd0;
      dec_use_rs1 = 1'b1; dec_rs1 = 5'd0; tick();
      clr(); tick();

      // normal drain
      issue_wr(5'd3); issue_wr(5'd4); issue_wr(5'd4);
      clr(); drain_req = 1'b1; tick();
      retire(5'd3); retire(5'd4); retire(5'd4);
      clr(); tick(); tick();
      drain_req = 1'b0; tick(); tick();

      // drain under external stall, then abandoned drain
      issue_wr(5'd6); issue_wr(5'd6);
      clr(); mstall_n = 1'b0; drain_req = 1'b1; tick();
      mstall_n = 1'b0; wb_valid = 1'b1; wb_rd = 5'd6; tick();
      clr(); tick();
      drain_req = 1'b0; tick(); tick();
      retire(5'd6);
      clr(); drain_req = 1'b1; tick(); tick(); tick();
      drain_req = 1'b0; tick();

      // randomized traffic
      for (int n = 0; n < 4000; n++) begin
         if ($urandom_range(0, 299) == 0) do_reset();
         mstall_n    = ($urandom_range(0, 9) != 0);
         if ($urandom_range(0, 15) == 0) drain_req = ~drain_req;
         dec_valid   = ($urandom_range(0, 3) != 0);
         dec_we      = ($urandom_range(0, 3) != 0);
         dec_rd      = 5'($urandom_range(0, 7));
         dec_rs1     = 5'($urandom_range(0, 7));
         dec_rs2     = 5'($urandom_range(0, 7));
         dec_use_rs1 = 1'($urandom_range(0, 1));
         dec_use_rs2 = 1'($urandom_range(0, 1));
         wb_valid    = 1'($urandom_range(0, 1));
         wb_rd       = ($urandom_range(0, 31) == 0) ? 5'($urandom_range(0, 7)) : pick_pending();
         for (int c = 0; c < NUM_CANCEL; c++) begin
            cancel_valid[c]    = ($urandom_range(0, 7) == 0);
            cancel_rd[5*c +: 5] = pick_pending();
         end
         tick();
      end

      clr(); drain_req = 1'b0;
      tick(); tick();
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL queue_drain got=%0d pending exp=0", exp_q.size());
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
